// File: rtl/isp8_wb_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : isp8_wb_bridge
// Purpose  : Turns the single-cycle external access strobes of the isp8 I/O
//            control stage into Wishbone B3 classic single transfers. Returns
//            read data plus a one-cycle completion pulse to the core, and keeps
//            the core stalled (ext_busy) while a transfer is outstanding.
// Ports    : clk, rst_n (async, active-low)
//            ext_addr/ext_dout/ext_mem_wr/ext_mem_rd/ext_io_wr/ext_io_rd : core request
//            ext_din/ext_ready/ext_busy : core response
//            bus_err (sticky), err_clr   : error status
//            wb_cyc_o/wb_stb_o/wb_we_o/wb_adr_o/wb_dat_o : Wishbone master
//            wb_dat_i/wb_ack_i/wb_err_i                  : Wishbone slave reply
// Options  : ISP8_WB_TIMEOUT_EN - adds a TMO_W-bit watchdog that ends a silent
//            transfer as an error after 2^TMO_W-1 XFER cycles.
// Revision : 1.0 - initial release
// ============================================================================
module isp8_wb_bridge #(
  parameter int PORT_AW = 8,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PORT_AW-1:0] ext_addr,
  input  logic [7:0]         ext_dout,
  input  logic               ext_mem_wr,
  input  logic               ext_mem_rd,
  input  logic               ext_io_wr,
  input  logic               ext_io_rd,
  output logic [7:0]         ext_din,
  output logic               ext_ready,
  output logic               ext_busy,
  output logic               bus_err,
  input  logic               err_clr,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [PORT_AW:0]   wb_adr_o,
  output logic [7:0]         wb_dat_o,
  input  logic [7:0]         wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [3:0] strobes;
  logic       any_strobe;
  logic       multi_strobe;
  logic       sel_we;
  logic       sel_io;
  logic       tmo_hit;
  logic       err_term;
  logic       err_set;

  assign strobes      = {ext_mem_wr, ext_mem_rd, ext_io_wr, ext_io_rd};
  assign any_strobe   = |strobes;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_strobe = (strobes & (strobes - 4'd1)) != 4'd0;

  // Priority mem_wr > mem_rd > io_wr > io_rd resolved into direction and space.
  assign sel_we = ext_mem_wr | (~ext_mem_rd & ext_io_wr);
  assign sel_io = ~ext_mem_wr & ~ext_mem_rd;

`ifdef ISP8_WB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counter is zero on every XFER entry; the cycle in which it would step to
  // all-ones is the last one the slave gets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (state == XFER) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  // Watchdog absent: TMO_W only sizes the optional counter, so this is 0.
  assign tmo_hit = (TMO_W < 1);
`endif

  assign err_term = wb_err_i | tmo_hit;

  // Dropped strobes (collision in IDLE, or any strobe while busy) and failed
  // terminations all raise the sticky error.
  assign err_set = (state == IDLE) ? multi_strobe
                                   : (any_strobe | ((state == XFER) & err_term));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ext_din   <= 8'h00;
      ext_ready <= 1'b0;
      ext_busy  <= 1'b0;
      bus_err   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= 8'h00;
    end else begin
      ext_ready <= 1'b0;

      if (err_set) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_strobe) begin
            wb_adr_o <= {sel_io, ext_addr};
            wb_dat_o <= ext_dout;
            wb_we_o  <= sel_we;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            ext_busy <= 1'b1;
            state    <= XFER;
          end
        end

        XFER: begin
          if (err_term || wb_ack_i) begin
            if (err_term) begin
              ext_din <= 8'hFF;
            end else if (!wb_we_o) begin
              ext_din <= wb_dat_i;
            end
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            ext_busy  <= 1'b0;
            ext_ready <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isp8_wb_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_isp8_wb_bridge
// Purpose  : Self-checking bench for isp8_wb_bridge. Directed cases followed
//            by randomized transfers against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isp8_wb_bridge;

  localparam int AW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [7:0]    ext_dout = '0;
  logic          ext_mem_wr = 1'b0, ext_mem_rd = 1'b0, ext_io_wr = 1'b0, ext_io_rd = 1'b0;
  logic [7:0]    ext_din;
  logic          ext_ready, ext_busy, bus_err;
  logic          err_clr = 1'b0;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW:0]   wb_adr_o;
  logic [7:0]    wb_dat_o;
  logic [7:0]    wb_dat_i = '0;
  logic          wb_ack_i = 1'b0, wb_err_i = 1'b0;

  isp8_wb_bridge #(.PORT_AW(AW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ext_addr(ext_addr), .ext_dout(ext_dout),
    .ext_mem_wr(ext_mem_wr), .ext_mem_rd(ext_mem_rd),
    .ext_io_wr(ext_io_wr), .ext_io_rd(ext_io_rd),
    .ext_din(ext_din), .ext_ready(ext_ready), .ext_busy(ext_busy),
    .bus_err(bus_err), .err_clr(err_clr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: last read value seen by the core and sticky error flag.
  logic [7:0] m_din = 8'h00;
  logic       m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer. strb = {mem_wr, mem_rd, io_wr, io_rd}.
  task automatic xfer(input logic [3:0] strb, input logic [7:0] addr, input logic [7:0] data,
                      input int waits, input logic [7:0] sdat, input logic serr,
                      input logic sack, input logic stray, input logic clr);
    int   win;
    logic exp_we;
    logic [8:0] exp_adr;
    win = -1;
    for (int i = 3; i >= 0; i--) if (strb[i] && win < 0) win = i;
    exp_we  = (win == 3) || (win == 1);
    exp_adr = {(win <= 1), addr};
    check("idle_busy", ext_busy, 0);
    check("idle_cyc", wb_cyc_o, 0);
    {ext_mem_wr, ext_mem_rd, ext_io_wr, ext_io_rd} = strb;
    ext_addr = addr;
    ext_dout = data;
    err_clr  = clr;
    if ($countones(strb) > 1) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    tick;
    {ext_mem_wr, ext_mem_rd, ext_io_wr, ext_io_rd} = 4'b0000;
    err_clr  = 1'b0;
    ext_addr = AW'($urandom);
    ext_dout = 8'($urandom);
    for (int c = 0; c < waits; c++) begin
      check("xfer_cyc", wb_cyc_o, 1);
      check("xfer_stb", wb_stb_o, 1);
      check("xfer_busy", ext_busy, 1);
      check("xfer_ready", ext_ready, 0);
      check("xfer_adr", wb_adr_o, exp_adr);
      check("xfer_we", wb_we_o, exp_we);
      if (exp_we) check("xfer_dat_o", wb_dat_o, data);
      if (stray && c == 0) begin
        ext_io_rd = 1'b1;
        m_err = 1'b1;
      end
      tick;
      ext_io_rd = 1'b0;
    end
    check("term_cyc", wb_cyc_o, 1);
    check("term_adr", wb_adr_o, exp_adr);
    check("term_we", wb_we_o, exp_we);
    if (exp_we) check("term_dat_o", wb_dat_o, data);
    wb_ack_i = sack;
    wb_err_i = serr;
    wb_dat_i = sdat;
    tick;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 8'($urandom);
    if (serr) begin
      m_din = 8'hFF;
      m_err = 1'b1;
    end else if (!exp_we) begin
      m_din = sdat;
    end
    check("done_ready", ext_ready, 1);
    check("done_cyc", wb_cyc_o, 0);
    check("done_stb", wb_stb_o, 0);
    check("done_busy", ext_busy, 0);
    check("done_din", ext_din, m_din);
    check("done_bus_err", bus_err, m_err);
    // An ack outside XFER must be ignored.
    wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    check("idle_ready", ext_ready, 0);
    check("idle_cyc2", wb_cyc_o, 0);
    check("idle_din", ext_din, m_din);
  endtask

  task automatic clear_err;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", bus_err, 0);
  endtask

  initial begin
    int cnt;
    logic [3:0] strb;
    logic       serr;

    // Reset state
    rst_n = 1'b0;
    tick; tick;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    check("rst_din", ext_din, 0);
    check("rst_ready", ext_ready, 0);
    check("rst_busy", ext_busy, 0);
    check("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;
    tick;

    // io_wr 0x12/0x5A, zero-wait slave
    xfer(4'b0010, 8'h12, 8'h5A, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    // mem_rd 0x40, four wait states, data 0xC3
    xfer(4'b0100, 8'h40, 8'h00, 4, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    // io_rd answered with err and ack together
    xfer(4'b0001, 8'h07, 8'h00, 1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    clear_err();
    // mem_wr + io_rd collision: memory write wins, error flagged
    xfer(4'b1001, 8'h9C, 8'hE1, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_err();
    // Collision in the same cycle as err_clr: set wins
    xfer(4'b0110, 8'h21, 8'h44, 2, 8'h6B, 1'b0, 1'b1, 1'b0, 1'b1);
    clear_err();
    // Strobe while a transfer is outstanding is dropped and flagged
    xfer(4'b0100, 8'h55, 8'h00, 3, 8'h19, 1'b0, 1'b1, 1'b1, 1'b0);
    clear_err();

    // Randomized transfers
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 7) strb = 4'b0001 << $urandom_range(0, 3);
      else strb = 4'($urandom_range(1, 15));
      // Error replies only on reads (winner is mem_rd or io_rd).
      serr = ($urandom_range(0, 4) == 0) && !strb[3] && (strb[2] || !strb[1]);
      xfer(strb, 8'($urandom), 8'($urandom), $urandom_range(0, 5), 8'($urandom),
           serr, serr ? 1'($urandom) : 1'b1, ($urandom_range(0, 5) == 0), 1'($urandom));
      if ($urandom_range(0, 2) == 0) clear_err();
    end
    clear_err();

    // Silent slave
    ext_mem_rd = 1'b1;
    ext_addr   = 8'h3E;
    tick;
    ext_mem_rd = 1'b0;
`ifdef ISP8_WB_TIMEOUT_EN
    cnt = 0;
    while (wb_cyc_o && cnt < 100) begin
      cnt++;
      tick;
    end
    m_din = 8'hFF;
    m_err = 1'b1;
    check("tmo_cycles", cnt, 15);
    check("tmo_ready", ext_ready, 1);
    check("tmo_din", ext_din, m_din);
    check("tmo_bus_err", bus_err, m_err);
    tick;
    clear_err();
    // Start a transfer to be cut by reset
    ext_mem_rd = 1'b1;
    tick;
    ext_mem_rd = 1'b0;
    tick;
`else
    cnt = 0;
    repeat (1000) begin
      tick;
      if (!wb_cyc_o) cnt++;
    end
    check("hang_cyc", wb_cyc_o, 1);
    check("hang_busy", ext_busy, 1);
    check("hang_drops", cnt, 0);
`endif
    check("pre_rst_cyc", wb_cyc_o, 1);

    // Asynchronous reset in the middle of XFER
    rst_n = 1'b0;
    #1;
    m_din = 8'h00;
    m_err = 1'b0;
    check("arst_cyc", wb_cyc_o, 0);
    check("arst_stb", wb_stb_o, 0);
    check("arst_busy", ext_busy, 0);
    check("arst_ready", ext_ready, 0);
    check("arst_din", ext_din, 0);
    tick;
    check("arst_ready2", ext_ready, 0);
    rst_n = 1'b1;
    tick;
    check("post_rst_ready", ext_ready, 0);
    xfer(4'b0010, 8'hA5, 8'h3C, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/isp8_wb_bridge.md
# isp8_wb_bridge

Converts the registered single-cycle external access strobes from the isp8 I/O control stage into Wishbone B3 classic single transfers. Returns read data and a completion pulse to the core, and holds the core in wait state while a transfer is outstanding. It sits directly downstream of the I/O control stage and is the only path from the isp8 core to memory-mapped and port-mapped peripherals.

## Interface
- PORT_AW, 8: external address width, 1..16
- TMO_W, 8: watchdog counter width; timeout after 2^TMO_W−1 cycles without ack/err
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ext_addr  in  PORT_AW  access address, valid in the strobe cycle
- ext_dout  in  8  write data, valid in the strobe cycle
- ext_mem_wr, ext_mem_rd, ext_io_wr, ext_io_rd  in  1 each  access strobes, 1-cycle pulses
- ext_din  out  8  read data returned to core
- ext_ready  out  1  1-cycle completion pulse (read or write)
- ext_busy  out  1  high while a transfer is outstanding; core must stall
- bus_err  out  1  sticky; set on wb_err_i or timeout
- err_clr  in  1  clears bus_err
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls
- wb_adr_o  out  PORT_AW+1  {space, ext_addr}; space=1 for I/O, 0 for memory
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i, wb_err_i  in  1 each  slave termination

## Operation
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- States: IDLE, XFER, DONE.
- IDLE: on any strobe, latch address, data, we and space. Go to XFER. Assert cyc/stb/busy.
- Strobe priority if several are high together: mem_wr > mem_rd > io_wr > io_rd. Lower-priority strobes are dropped, and bus_err is set.
- XFER: hold cyc/stb/we/adr/dat_o stable.
  - On wb_ack_i: for a read, capture wb_dat_i into ext_din. Go to DONE.
  - On wb_err_i (with or without ack): ext_din=8'hFF, set bus_err. Go to DONE. err takes precedence over ack.
- DONE: cyc/stb low, ext_ready=1, busy=0. Go to IDLE next cycle.
- A strobe arriving during XFER or DONE is dropped and sets bus_err. An ack/err arriving outside XFER is ignored.
- ext_din holds its value until the next completed read. It is unchanged by writes.
- err_clr clears bus_err. A set event in the same cycle wins.
- Reset mid-transfer: cyc/stb drop immediately (async), FSM returns to IDLE, and no ready pulse is issued.

## Timing
- Strobe at edge N → cyc/stb/busy high after edge N+1.
- Zero-wait slave (ack sampled at edge N+2) → cyc/stb low and ext_ready high after N+2; busy low after N+2.
- Minimum transfer is 3 cycles strobe-to-ready. Each slave wait state adds 1 cycle.
- Back-to-back: the next strobe is accepted in the cycle after ext_ready, i.e. while in IDLE.
- wb_adr_o, wb_dat_o and wb_we_o are registered and remain unchanged from cyc rise to cyc fall.

## Configuration
- ISP8_WB_TIMEOUT_EN defined: a TMO_W-bit counter clears on entry to XFER and increments each XFER cycle. When it reaches all-ones without ack/err, the transfer terminates as an error: ext_din=8'hFF, bus_err set, DONE.
- Not defined: no counter is synthesized, and XFER waits indefinitely for ack/err.

## Test plan
- io_wr, addr 0x12, data 0x5A, zero-wait slave → wb_adr_o=0x112, we=1, dat_o=0x5A; ext_ready 3 cycles after strobe; bus_err=0.
- mem_rd, addr 0x40, slave acks after 4 waits with 0xC3 → ext_din=0xC3, ext_ready 7 cycles after strobe, busy high for 6 cycles.
- io_rd answered with wb_err_i=1 and ack=1 together → ext_din=0xFF, bus_err=1. After err_clr pulse → bus_err=0.
- mem_wr and io_rd strobed together → only a memory write issues (adr bit PORT_AW=0); bus_err=1.
- With ISP8_WB_TIMEOUT_EN, TMO_W=4, silent slave → termination after 15 XFER cycles, ext_din=0xFF, bus_err=1. Without the macro → cyc still high after 1000 cycles.
- rst_n low during XFER → cyc/stb/busy 0 immediately; no ext_ready. After release, an io_wr completes normally.
